// File: rtl/dwconv_pkg.sv
// dwconv_pkg: shared tap layout, accumulator sizing and saturation helpers for the depthwise engine.
package dwconv_pkg;
    localparam int TAP_BIAS    = 9;
    localparam int TAPS_PER_CH = 10;

    function automatic int acc_width(input int dw, input int ww);
        return dw + ww + 4;
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int dw);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        return v > hi ? hi : (v < lo ? lo : v);
    endfunction
endpackage

// File: rtl/dwconv3x3_stream_nch_if.sv
// dwconv3x3_stream_nch_if: pixel stream, weight-load port and result stream of the depthwise engine.
interface dwconv3x3_stream_nch_if
    import dwconv_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int WEIGHT_WIDTH = 16,
    parameter int CHANNELS     = 32
);
    localparam int AW = $clog2(CHANNELS * TAPS_PER_CH);
    logic                           Valid_In;
    logic [DATA_WIDTH*CHANNELS-1:0] Data_In;
    logic                           Wgt_We;
    logic [AW-1:0]                  Wgt_Addr;
    logic [WEIGHT_WIDTH-1:0]        Wgt_Data;
    logic                           Busy;
    logic                           Valid_Out;
    logic [DATA_WIDTH*CHANNELS-1:0] Data_Out;

    modport master (output Valid_In, Data_In, Wgt_We, Wgt_Addr, Wgt_Data, input Busy, Valid_Out, Data_Out);
    modport slave  (input Valid_In, Data_In, Wgt_We, Wgt_Addr, Wgt_Data, output Busy, Valid_Out, Data_Out);
endinterface

// File: rtl/dwconv_line_buffer.sv
// dwconv_line_buffer: two-row delay addressed by column; row1/row2 are the pixels one and two rows above.
module dwconv_line_buffer #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 44,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] row1,
    output logic [WIDTH-1:0] row2
);
    logic [WIDTH-1:0] mem1 [DEPTH];
    logic [WIDTH-1:0] mem2 [DEPTH];

    assign row1 = mem1[addr];
    assign row2 = mem2[addr];

    always_ff @(posedge clk)
        if (en) begin
            mem1[addr] <= din;
            mem2[addr] <= mem1[addr];
        end
endmodule

// File: rtl/dwconv3x3_stream_nch.sv
// dwconv3x3_stream_nch: streaming 3x3 depthwise convolution, VALID padding, stride 1 or 2, 3-stage datapath.
// Define DWCONV_RELU_EN to clamp negative results to zero.
module dwconv3x3_stream_nch
    import dwconv_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int WEIGHT_WIDTH = 16,
    parameter int FRAC_BITS    = 8,
    parameter int CHANNELS     = 32,
    parameter int IMG_WIDTH    = 44,
    parameter int IMG_HEIGHT   = 44,
    parameter int STRIDE       = 1
) (
    input logic clk,
    input logic rst,
    dwconv3x3_stream_nch_if.slave bus
);
    localparam int PIX_W  = DATA_WIDTH * CHANNELS;
    localparam int PROD_W = DATA_WIDTH + WEIGHT_WIDTH;
    localparam int ACC_W  = acc_width(DATA_WIDTH, WEIGHT_WIDTH);
    localparam int NW     = CHANNELS * TAPS_PER_CH;
    localparam int AW     = $clog2(NW);
    localparam int CW     = $clog2(IMG_WIDTH);
    localparam int RW     = $clog2(IMG_HEIGHT);

    if (STRIDE != 1 && STRIDE != 2) begin : g_bad_stride
        $error("dwconv3x3_stream_nch: STRIDE must be 1 or 2");
    end

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic col_last, row_last, busy, emit, s1_valid, s2_valid, valid_out;
    logic [PIX_W-1:0] data_out, res_all, up1, up2;
    logic [PIX_W-1:0] live [3];
    logic [PIX_W-1:0] win [3][2];
    logic [PIX_W-1:0] tap_px [9];
    logic signed [WEIGHT_WIDTH-1:0] wgt [NW];

    assign col_last = col == CW'(IMG_WIDTH - 1);
    assign row_last = row == RW'(IMG_HEIGHT - 1);
    // With stride 2 the (row-2)/(col-2) parity test reduces to row/col being even.
    assign emit = bus.Valid_In && row >= RW'(2) && col >= CW'(2) && (STRIDE == 1 || !(row[0] || col[0]));
    assign live = '{up2, up1, bus.Data_In};
    assign bus.Busy = busy;
    assign bus.Valid_Out = valid_out;
    assign bus.Data_Out = data_out;

    dwconv_line_buffer #(.WIDTH(PIX_W), .DEPTH(IMG_WIDTH), .AW(CW)) u_line_buffer (
        .clk(clk), .en(bus.Valid_In), .addr(col), .din(bus.Data_In), .row1(up1), .row2(up2)
    );

    // The window keeps the two older columns; the newest column is taken live so S1 sees the current pixel.
    always_ff @(posedge clk)
        if (bus.Valid_In)
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= live[r];
            end

    always_comb
        for (int r = 0; r < 3; r++) begin
            tap_px[3*r]   = win[r][0];
            tap_px[3*r+1] = win[r][1];
            tap_px[3*r+2] = live[r];
        end

    always_ff @(posedge clk)
        if (bus.Wgt_We && !busy && !bus.Valid_In && {1'b0, bus.Wgt_Addr} < (AW+1)'(NW))
            wgt[bus.Wgt_Addr] <= $signed(bus.Wgt_Data);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic signed [PROD_W-1:0] prod [9];
        logic signed [WEIGHT_WIDTH-1:0] bias;
        logic signed [ACC_W-1:0] sum, acc;
        logic signed [63:0] sh;
        // Bias is captured with the products so a weight load during drain cannot disturb it.
        always_ff @(posedge clk)
            if (emit) begin
                for (int t = 0; t < 9; t++)
                    prod[t] <= PROD_W'($signed(tap_px[t][k*DATA_WIDTH +: DATA_WIDTH])) * PROD_W'(wgt[k*TAPS_PER_CH + t]);
                bias <= wgt[k*TAPS_PER_CH + TAP_BIAS];
            end
        always_comb begin
            sum = ACC_W'(bias) <<< FRAC_BITS;
            for (int t = 0; t < 9; t++) sum = sum + ACC_W'(prod[t]);
        end
        always_ff @(posedge clk)
            if (s1_valid) acc <= sum;
        assign sh = 64'(acc >>> FRAC_BITS);
`ifdef DWCONV_RELU_EN
        assign res_all[k*DATA_WIDTH +: DATA_WIDTH] = sh < 0 ? '0 : DATA_WIDTH'(saturate(sh, DATA_WIDTH));
`else
        assign res_all[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(saturate(sh, DATA_WIDTH));
`endif
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            col       <= '0;
            row       <= '0;
            busy      <= 1'b0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            valid_out <= 1'b0;
            data_out  <= '0;
        end else begin
            if (bus.Valid_In) begin
                col  <= col_last ? '0 : col + 1'b1;
                row  <= col_last ? (row_last ? '0 : row + 1'b1) : row;
                busy <= !(col_last && row_last);
            end
            s1_valid  <= emit;
            s2_valid  <= s1_valid;
            valid_out <= s2_valid;
            if (s2_valid) data_out <= res_all;
        end
endmodule

// File: doc/dwconv3x3_stream_nch.md
Name: dwconv3x3_stream_nch

Overview:
- Parametrised streaming 3x3 depthwise convolution engine for the separable-convolution layers; it is the successor to the fixed 32-channel depthwise stages.
- Channel count, data/weight widths, image size and stride are all parameters.
- It holds its own line buffers, window registers, weight/bias storage loaded at run time, and a saturating fixed-point datapath.
- It sits between a layer's input stream and its pointwise stage: one pixel, all channels, per Valid_In beat.

Parameters:
- DATA_WIDTH, 16, signed two's-complement width per channel sample.
- WEIGHT_WIDTH, 16, signed weight and bias width.
- FRAC_BITS, 8, arithmetic right shift applied to the accumulator before saturation.
- CHANNELS, 32, number of independent channels per pixel.
- IMG_WIDTH, 44, input columns.
- IMG_HEIGHT, 44, input rows.
- STRIDE, 1, legal values are 1 or 2; any other value is an elaboration error.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- Valid_In  in  1  Data_In holds one pixel this cycle.
- Data_In  in  DATA_WIDTH*CHANNELS  pixel; channel k is in bits [k*DATA_WIDTH +: DATA_WIDTH].
- Wgt_We  in  1  weight/bias write strobe.
- Wgt_Addr  in  clog2(CHANNELS*10)  write address; address = ch*10+tap, tap 0..8 raster order, tap 9 is the bias.
- Wgt_Data  in  WEIGHT_WIDTH  write data.
- Busy  out  1  a frame is in progress.
- Valid_Out  out  1  Data_Out holds a result.
- Data_Out  out  DATA_WIDTH*CHANNELS  result, same channel packing as Data_In.

Behaviour:
- Reset (async, active-high):
  - Valid_Out=0, Data_Out=0, Busy=0.
  - Row/column counters cleared; pipeline valid bits cleared.
  - Weight/bias RAM is not cleared; it retains its contents.
- Counters:
  - col advances on each Valid_In and wraps at IMG_WIDTH-1.
  - row advances when col wraps; after the last pixel (row=IMG_HEIGHT-1, col=IMG_WIDTH-1) both return to 0.
  - Busy rises on the first accepted pixel and falls on the cycle after the last pixel is accepted.
- Buffering: two line buffers of IMG_WIDTH x CHANNELS x DATA_WIDTH, plus a 3x3xCHANNELS window shift register that shifts only on Valid_In.
- Padding: VALID only, no padding. Output size is ((IMG_HEIGHT-3)/STRIDE+1) x ((IMG_WIDTH-3)/STRIDE+1).
- Window emission: a window is emitted on an accepted pixel when all of the following hold:
  - row>=2 and col>=2;
  - (row-2)%STRIDE==0 and (col-2)%STRIDE==0.
  - Columns 0..1 of each row never produce output; there is no cross-row wrap-around window.
- Datapath (3 stages, each with a valid bit):
  - S1 registers the 9 products per channel.
  - S2 registers the sum of the 9 products plus the bias shifted left by FRAC_BITS. Accumulator width is DATA_WIDTH+WEIGHT_WIDTH+4.
  - S3 applies an arithmetic shift right by FRAC_BITS, then saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] and registers Data_Out and Valid_Out.
- Latency: Valid_Out is asserted exactly 3 cycles after the emitting Valid_In cycle, independent of input gaps. There is no backpressure; the consumer must accept every Valid_Out beat.
- Data_Out holds its last value while Valid_Out=0.
- Weight writes:
  - Wgt_We is honoured only when Busy=0 and Valid_In=0 in the same cycle.
  - Otherwise the write is dropped silently.
  - Addresses >= CHANNELS*10 are ignored.
- Reset mid-frame: the partial frame is discarded and no further Valid_Out pulses occur for it. The next Valid_In is treated as pixel (0,0).
- Frames are back to back: pixel (0,0) of frame N+1 may arrive the cycle after the last pixel of frame N, and the S1-S3 outputs of frame N drain normally.

Optional Feature:
- Macro: DWCONV_RELU_EN.
- Defined: S3 clamps negative saturated results to 0 per channel. Latency is unchanged.
- Undefined: signed output as above.

Decomposition:
- Shared package dwconv_pkg holds:
  - the tap-index localparams (TAP_BIAS=9, TAPS_PER_CH=10);
  - the accumulator-width function;
  - the saturate function.
- One natural sub-module, dwconv_line_buffer: a parameterised 2-row delay that advances on enable. It is instantiated once with width CHANNELS*DATA_WIDTH.

Test Plan:
- Basic window sums:
  - Setup: CHANNELS=2, 4x4 image, FRAC_BITS=0, all weights 1, bias 0; pixel value r*4+c on both channels.
  - Expected: exactly 4 Valid_Out beats with values 45, 54, 81, 90 on both channels, each 3 cycles after pixels (2,2), (2,3), (3,2), (3,3).
- Stride 2 with input gaps:
  - Setup: STRIDE=2, 5x5 image, same weights, input gaps of 1-3 idle cycles.
  - Expected: exactly 4 outputs, centred on (1,1), (1,3), (3,1), (3,3); latency stays 3 cycles.
- Saturation:
  - Setup: DATA_WIDTH=16, FRAC_BITS=0, weights 1.
  - All inputs 32767 -> outputs 32767.
  - All inputs -32768 -> outputs -32768.
  - Bias 5 with zero inputs -> output 5.
- Weight write gating:
  - Stimulus: write tap0 of ch1 = 3 while Busy=1.
  - Expected: the following frame's results are unchanged; after the same write with Busy=0, the ch1 result changes by 2*pixel(r-2,c-2).
- Reset mid-frame:
  - Stimulus: assert rst at pixel (2,1); deassert it and send a full frame.
  - Expected: the output count is exactly 4 and the values match the basic test.
- ReLU:
  - Setup: with DWCONV_RELU_EN, weights all -1.
  - Expected: all outputs are 0. Without the macro, outputs are -45, -54, -81, -90.
